// File: rtl/reprogram_request.sv
// Host-side register front end for FPGA multiboot: key-unlocked, delayed, one-shot
// reprogram pulse carrying a captured flash start address to the IPROG sequencer.
module reprogram_request #(
    parameter int unsigned DELAY_CYCLES = 1000,
    parameter logic [31:0] KEY          = 32'h52455047
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic [2:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic        reprogram,
    output logic [31:0] address,
    output logic        busy
);

    localparam int unsigned CW = (DELAY_CYCLES == 0) ? 1 : $clog2(DELAY_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNLOCKED,
        S_DELAY,
        S_FIRE,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    key_idx_q, key_idx_d;
    logic [31:0]   addr_reg_q, addr_reg_d;
    logic [31:0]   address_q, address_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic [7:0]    key_byte;
    logic          addr_wr_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            key_idx_q  <= '0;
            addr_reg_q <= '0;
            address_q  <= '0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            key_idx_q  <= key_idx_d;
            addr_reg_q <= addr_reg_d;
            address_q  <= address_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Key byte expected next; the key is presented MSB first.
    always_comb begin
        key_byte = KEY[31:24];
        unique case (key_idx_q)
            2'd0: key_byte = KEY[31:24];
            2'd1: key_byte = KEY[23:16];
            2'd2: key_byte = KEY[15:8];
            2'd3: key_byte = KEY[7:0];
        endcase
    end

    assign addr_wr_ok = wr_en && !wr_addr[2] && (state_q == S_IDLE || state_q == S_UNLOCKED);

    always_comb begin
        state_d    = state_q;
        key_idx_d  = key_idx_q;
        addr_reg_d = addr_reg_q;
        address_d  = address_q;
        cnt_d      = cnt_q;

        if (addr_wr_ok) begin
            unique case (wr_addr[1:0])
                2'd0: addr_reg_d[7:0]   = wr_data;
                2'd1: addr_reg_d[15:8]  = wr_data;
                2'd2: addr_reg_d[23:16] = wr_data;
                2'd3: addr_reg_d[31:24] = wr_data;
            endcase
        end

        unique case (state_q)
            S_IDLE: begin
                if (wr_en && wr_addr == 3'd4) begin
                    if (wr_data == key_byte) begin
                        if (key_idx_q == 2'd3) begin
                            state_d   = S_UNLOCKED;
                            key_idx_d = '0;
                        end else begin
                            key_idx_d = key_idx_q + 2'd1;
                        end
                    end else begin
                        // A mismatching byte may itself start a fresh sequence.
                        key_idx_d = (wr_data == KEY[31:24]) ? 2'd1 : 2'd0;
                    end
                end else if (wr_en && wr_addr == 3'd5) begin
                    key_idx_d = '0;
                end
            end
            S_UNLOCKED: begin
                if (wr_en && wr_addr == 3'd5) begin
                    if (wr_data[0]) begin
                        state_d   = S_DELAY;
                        address_d = addr_reg_q;
                        cnt_d     = CW'(DELAY_CYCLES);
                    end else begin
                        state_d   = S_IDLE;
                        key_idx_d = '0;
                    end
                end else if (wr_en && wr_addr == 3'd4) begin
                    state_d   = S_IDLE;
                    key_idx_d = '0;
                end
            end
            S_DELAY: begin
                if (cnt_q == '0) begin
                    state_d = S_FIRE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FIRE:  state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_data_d = '0;
        unique case (rd_addr)
            3'd0: rd_data_d = addr_reg_q[7:0];
            3'd1: rd_data_d = addr_reg_q[15:8];
            3'd2: rd_data_d = addr_reg_q[23:16];
            3'd3: rd_data_d = addr_reg_q[31:24];
            3'd5: rd_data_d = {5'b0, state_q == S_DONE, busy, state_q == S_UNLOCKED};
            default: rd_data_d = '0;
        endcase
    end

    assign rd_data   = rd_data_q;
    assign reprogram = (state_q == S_FIRE);
    assign address   = address_q;
    assign busy      = (state_q == S_DELAY) || (state_q == S_FIRE) || (state_q == S_DONE);

endmodule

// File: tb/tb_reprogram_request.sv
// Directed-vector bench: one instance with a 4-cycle delay, one with zero delay.
module tb_reprogram_request;

    logic        clk = 1'b0;
    logic        rst0_n = 1'b0;
    logic        rst1_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [2:0]  rd_addr = '0;
    logic [7:0]  rd_data0, rd_data1;
    logic        reprogram0, reprogram1;
    logic [31:0] address0, address1;
    logic        busy0, busy1;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    reprogram_request #(.DELAY_CYCLES(4)) dut0 (
        .clk(clk), .reset_n(rst0_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data0), .reprogram(reprogram0), .address(address0),
        .busy(busy0)
    );

    reprogram_request #(.DELAY_CYCLES(0)) dut1 (
        .clk(clk), .reset_n(rst1_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data1), .reprogram(reprogram1), .address(address1),
        .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All tasks are entered and left on a falling edge; each takes one cycle.
    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input bit sel, input logic [2:0] a, input logic [7:0] exp, input string tag);
        rd_addr = a;
        @(negedge clk);
        check(tag, sel ? rd_data1 : rd_data0, exp);
    endtask

    task automatic key_ok();
        wr(3'd4, 8'h52); wr(3'd4, 8'h45); wr(3'd4, 8'h50); wr(3'd4, 8'h47);
    endtask

    task automatic addr_bytes(input logic [31:0] a);
        wr(3'd0, a[7:0]); wr(3'd1, a[15:8]); wr(3'd2, a[23:16]); wr(3'd3, a[31:24]);
    endtask

    task automatic reset0();
        rst0_n = 1'b0;
        @(negedge clk);
        rst0_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst0_n = 1'b1;
        check("rst_reprogram", reprogram0, 0);
        check("rst_address", address0, 0);
        check("rst_busy", busy0, 0);
        rd(0, 3'd5, 8'h00, "rst_status");

        // 1: basic fire, 4-cycle delay -> pulse 5 cycles after trigger edge
        addr_bytes(32'h0040_0000);
        key_ok();
        rd(0, 3'd5, 8'h01, "t1_unlocked");
        wr(3'd5, 8'h01);
        check("t1_busy", busy0, 1);
        check("t1_address", address0, 32'h0040_0000);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            check($sformatf("t1_pulse_c%0d", i), reprogram0, (i == 5) ? 1 : 0);
        end
        rd(0, 3'd5, 8'h06, "t1_status_done");

        // 3: done is terminal
        wr(3'd5, 8'h01);
        key_ok();
        addr_bytes(32'hAABB_CCDD);
        wr(3'd5, 8'h01);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t3_no_pulse", reprogram0, 0);
        end
        check("t3_address", address0, 32'h0040_0000);
        rd(0, 3'd2, 8'h40, "t3_addr_b2");
        rd(0, 3'd0, 8'h00, "t3_addr_b0");
        rd(0, 3'd5, 8'h06, "t3_status");

        // 2: bad key, ignored trigger, then restart on 'R'
        reset0();
        wr(3'd4, 8'h52); wr(3'd4, 8'h45); wr(3'd4, 8'h00); wr(3'd4, 8'h47);
        wr(3'd5, 8'h01);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("t2_no_pulse", reprogram0, 0);
        end
        rd(0, 3'd5, 8'h00, "t2_status_locked");
        wr(3'd4, 8'h52); wr(3'd4, 8'h52); wr(3'd4, 8'h45); wr(3'd4, 8'h50); wr(3'd4, 8'h47);
        rd(0, 3'd5, 8'h01, "t2_status_unlocked");
        rd(0, 3'd4, 8'h00, "t2_key_reads_zero");

        // 4: addr writes during DELAY ignored, snapshot kept
        addr_bytes(32'h7856_3412);
        wr(3'd6, 8'hFF);
        rd(0, 3'd6, 8'h00, "t4_reserved");
        wr(3'd5, 8'h01);
        wr(3'd0, 8'hFF);
        rd(0, 3'd0, 8'h12, "t4_addr_b0_kept");
        for (int i = 3; i <= 7; i++) begin
            @(negedge clk);
            check($sformatf("t4_pulse_c%0d", i), reprogram0, (i == 5) ? 1 : 0);
        end
        check("t4_address", address0, 32'h7856_3412);

        // 5: reset mid-delay
        reset0();
        addr_bytes(32'h0040_0000);
        key_ok();
        wr(3'd5, 8'h01);
        @(negedge clk);
        @(negedge clk);
        rst0_n = 1'b0;
        #1;
        check("t5_rst_reprogram", reprogram0, 0);
        check("t5_rst_address", address0, 0);
        check("t5_rst_busy", busy0, 0);
        @(negedge clk);
        rst0_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t5_no_pulse", reprogram0, 0);
        end
        rd(0, 3'd5, 8'h00, "t5_status");
        addr_bytes(32'h0040_0000);
        key_ok();
        wr(3'd5, 8'h01);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            check($sformatf("t5_pulse_c%0d", i), reprogram0, (i == 5) ? 1 : 0);
        end
        check("t5_address", address0, 32'h0040_0000);

        // 6: zero-delay instance
        rst1_n = 1'b1;
        addr_bytes(32'h4433_2211);
        rd(1, 3'd0, 8'h11, "t6_rd_b0");
        rd(1, 3'd3, 8'h44, "t6_rd_b3");
        key_ok();
        wr(3'd5, 8'h01);
        check("t6_no_pulse_c0", reprogram1, 0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check($sformatf("t6_pulse_c%0d", i), reprogram1, (i == 1) ? 1 : 0);
        end
        check("t6_address", address1, 32'h4433_2211);
        rd(1, 3'd5, 8'h06, "t6_status");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
